tap_ctrl: RTL

- IEEE 1149.1 TAP controller and instruction register for the JTAG-to-AXI bridge, running in the `tck` domain.
- Tracks the 16-state TAP state machine from `tms` and owns the IR shift/update path.
- Decodes the latched instruction into `ir_dec` and multiplexes the IR or DR serial output onto the `tdo` pad.
- Sits directly upstream of `data_registers`: it drives that block's `tap_state` and `ir_dec`, and its `tdo_dr` input comes from that block's `tdo`.

---
 rtl/tap_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tap_ctrl.sv
// tap_ctrl: IEEE 1149.1 TAP state machine, instruction register and TDO mux.
// Runs entirely in the tck domain and feeds data_registers with state and decoded instruction.
package tap_ctrl_pkg;
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } tap_ctrl_fsm_t;

    typedef enum logic [2:0] {
        IDCODE,
        SAMPLE_PRELOAD,
        IC_RESET,
        ADDR_AXI_REGISTER,
        DATA_AXI_REGISTER,
        MGMT_AXI_REGISTER,
        BYPASS
    } ir_decoding_t;
endpackage

module tap_ctrl
    import tap_ctrl_pkg::*;
#(
    parameter int                    IR_WIDTH       = 4,
    parameter logic [IR_WIDTH-1:0]   IR_CAPTURE_VAL = IR_WIDTH'(4'b0101)
) (
    input  logic          trstn,
    input  logic          tck,
    input  logic          tms,
    input  logic          tdi,
    input  logic          tdo_dr,
    output logic          tdo,
    output logic          tdo_en,
    output tap_ctrl_fsm_t tap_state,
    output ir_decoding_t  ir_dec
);
    localparam logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(1);

    tap_ctrl_fsm_t       r_state;
    tap_ctrl_fsm_t       w_next;
    logic [IR_WIDTH-1:0] r_ir_sr;
    logic [IR_WIDTH-1:0] r_ir_ff;
    logic                r_ir_n;
    logic                r_tdo_en;
    logic                r_sel_ir;
    ir_decoding_t        w_dec;

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) r_state <= TEST_LOGIC_RESET;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TEST_LOGIC_RESET: w_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    w_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        w_next = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       w_next = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         w_next = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         w_next = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         w_next = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         w_next = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        w_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        w_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       w_next = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         w_next = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         w_next = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         w_next = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         w_next = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        w_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          w_next = TEST_LOGIC_RESET;
        endcase
    end

    // LSB leaves first, tdi enters at the MSB
    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn)                      r_ir_sr <= IR_CAPTURE_VAL;
        else if (r_state == CAPTURE_IR)  r_ir_sr <= IR_CAPTURE_VAL;
        else if (r_state == SHIFT_IR)    r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn)                           r_ir_ff <= IDCODE_OP;
        else if (r_state == UPDATE_IR)        r_ir_ff <= r_ir_sr;
        else if (r_state == TEST_LOGIC_RESET) r_ir_ff <= IDCODE_OP;
    end

    always_comb begin
        w_dec = (r_ir_ff == IR_WIDTH'(1)) ? IDCODE            :
                (r_ir_ff == IR_WIDTH'(2)) ? SAMPLE_PRELOAD    :
                (r_ir_ff == IR_WIDTH'(3)) ? IC_RESET          :
                (r_ir_ff == IR_WIDTH'(4)) ? ADDR_AXI_REGISTER :
                (r_ir_ff == IR_WIDTH'(5)) ? DATA_AXI_REGISTER :
                (r_ir_ff == IR_WIDTH'(6)) ? MGMT_AXI_REGISTER :
                                            BYPASS;
    end

    // Output side is retimed to falling tck so the pad is stable at the host's rising sample
    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            r_ir_n   <= 1'b0;
            r_tdo_en <= 1'b0;
            r_sel_ir <= 1'b0;
        end else begin
            r_ir_n   <= r_ir_sr[0];
            r_tdo_en <= (r_state == SHIFT_IR) || (r_state == SHIFT_DR);
            r_sel_ir <= (r_state == SHIFT_IR);
        end
    end

    assign tdo       = r_sel_ir ? r_ir_n : (r_tdo_en ? tdo_dr : 1'b0);
    assign tdo_en    = r_tdo_en;
    assign tap_state = r_state;
    assign ir_dec    = w_dec;
endmodule
